centroid_accumulator: RTL and testbench

- Parametrised successor to the k-means per-cluster accumulator.
- Accepts classified points over a valid/ready handshake and sums each dimension per cluster, with a per-cluster count.
- On an update request, computes new centroids (sum/count) with a shared serial restoring divider, one element at a time. Empty clusters keep their previous centroid.
- Reports convergence ("changed") and count overflow. Sits between the classifier stage and the centroid register file.

---
 rtl/centroid_accumulator.sv | 190 +++++++++++++++++++
 tb/tb_centroid_accumulator.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/centroid_accumulator.sv
// Per-cluster point accumulator with a shared serial restoring divider that
// turns sums/counts into new centroids one element at a time.
module centroid_accumulator #(
   parameter int N  = 3,
   parameter int D  = 2,
   parameter int W  = 32,
   parameter int CW = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      pt_valid,
   output logic                      pt_ready,
   input  logic [D*W-1:0]            pt_data,
   input  logic [N-1:0]              pt_class,
   input  logic                      clr,
   input  logic                      update_req,
   output logic                      busy,
   output logic                      done,
   output logic                      changed,
   output logic                      ovf,
   output logic [(2**N)*D*W-1:0]     new_centroids
);

   localparam int K   = 2**N;
   localparam int AW  = W + CW;
   localparam int JW  = (D > 1) ? $clog2(D) : 1;
   localparam int ITW = $clog2(AW + 1);

   typedef enum logic [1:0] {ACCUM, DIVIDE, FINISH} state_t;

   state_t                         state_q, state_d;
   logic [K-1:0][D-1:0][AW-1:0]    sum_q, sum_d;
   logic [K-1:0][CW-1:0]           cnt_q, cnt_d;
   logic [K-1:0][D-1:0][W-1:0]     cent_q, cent_d;
   logic                           busy_q, busy_d;
   logic                           done_q, done_d;
   logic                           changed_q, changed_d;
   logic                           ovf_q, ovf_d;
   logic [N-1:0]                   i_q, i_d;
   logic [JW-1:0]                  j_q, j_d;
   logic                           phase_q, phase_d;
   logic [ITW-1:0]                 it_q, it_d;
   logic [AW-1:0]                  rem_q, rem_d;
   logic [AW-1:0]                  quo_q, quo_d;

   logic [AW-1:0] divisor;
   logic [AW:0]   rem_sh, rem_try;
   logic          advance;

   assign divisor = {{W{1'b0}}, cnt_q[i_q]};
   // rem < divisor always, so the shifted remainder never reaches bit AW;
   // bit AW of the trial difference is the borrow.
   assign rem_sh  = {rem_q, quo_q[AW-1]};
   assign rem_try = rem_sh - {1'b0, divisor};

   always_comb begin
      state_d   = state_q;
      sum_d     = sum_q;
      cnt_d     = cnt_q;
      cent_d    = cent_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      changed_d = changed_q;
      ovf_d     = ovf_q;
      i_d       = i_q;
      j_d       = j_q;
      phase_d   = phase_q;
      it_d      = it_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      advance   = 1'b0;
      case (state_q)
         ACCUM: begin
            if (clr) begin
               sum_d = '0;
               cnt_d = '0;
               ovf_d = 1'b0;
            end else begin
               if (pt_valid) begin
                  if (cnt_q[pt_class] == '1) begin
                     ovf_d = 1'b1;
                  end else begin
                     cnt_d[pt_class] = cnt_q[pt_class] + CW'(1);
                     for (int j = 0; j < D; j++)
                        sum_d[pt_class][j] = sum_q[pt_class][j] + AW'(pt_data[j*W +: W]);
                  end
               end
               if (update_req) begin
                  state_d   = DIVIDE;
                  busy_d    = 1'b1;
                  changed_d = 1'b0;
                  i_d       = '0;
                  j_d       = '0;
                  phase_d   = 1'b0;
               end
            end
         end
         DIVIDE: begin
            if (!phase_q) begin
               if (cnt_q[i_q] == '0) begin
                  advance = 1'b1;
               end else begin
                  rem_d   = '0;
                  quo_d   = sum_q[i_q][j_q];
                  it_d    = '0;
                  phase_d = 1'b1;
               end
            end else begin
               if (!rem_try[AW]) begin
                  rem_d = rem_try[AW-1:0];
                  quo_d = {quo_q[AW-2:0], 1'b1};
               end else begin
                  rem_d = rem_sh[AW-1:0];
                  quo_d = {quo_q[AW-2:0], 1'b0};
               end
               it_d = it_q + ITW'(1);
               if (it_q == ITW'(AW-1)) begin
                  cent_d[i_q][j_q] = quo_d[W-1:0];
                  if (quo_d[W-1:0] != cent_q[i_q][j_q])
                     changed_d = 1'b1;
                  phase_d = 1'b0;
                  advance = 1'b1;
               end
            end
            if (advance) begin
               if (j_q == JW'(D-1)) begin
                  j_d = '0;
                  if (i_q == N'(K-1))
                     state_d = FINISH;
                  else
                     i_d = i_q + N'(1);
               end else begin
                  j_d = j_q + JW'(1);
               end
            end
         end
         FINISH: begin
            sum_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ACCUM;
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ACCUM;
         sum_q     <= '0;
         cnt_q     <= '0;
         cent_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         changed_q <= 1'b0;
         ovf_q     <= 1'b0;
         i_q       <= '0;
         j_q       <= '0;
         phase_q   <= 1'b0;
         it_q      <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
      end else begin
         state_q   <= state_d;
         sum_q     <= sum_d;
         cnt_q     <= cnt_d;
         cent_q    <= cent_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         changed_q <= changed_d;
         ovf_q     <= ovf_d;
         i_q       <= i_d;
         j_q       <= j_d;
         phase_q   <= phase_d;
         it_q      <= it_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
      end
   end

   assign pt_ready      = (state_q == ACCUM);
   assign busy          = busy_q;
   assign done          = done_q;
   assign changed       = changed_q;
   assign ovf           = ovf_q;
   assign new_centroids = cent_q;

endmodule

// File: tb/tb_centroid_accumulator.sv
// Scoreboard bench: stimulus pushes expected centroids/latency per update,
// a negedge monitor pops and compares whenever done pulses.
module tb_centroid_accumulator;
   localparam int N = 2, D = 2, W = 8, CW = 8;
   localparam int K = 4;

   logic clk, rst, pt_valid, pt_ready, clr, update_req, busy, done, changed, ovf;
   logic [D*W-1:0]   pt_data;
   logic [N-1:0]     pt_class;
   logic [K*D*W-1:0] new_centroids;

   centroid_accumulator #(.N(N), .D(D), .W(W), .CW(CW)) dut (
      .clk(clk), .rst(rst), .pt_valid(pt_valid), .pt_ready(pt_ready),
      .pt_data(pt_data), .pt_class(pt_class), .clr(clr), .update_req(update_req),
      .busy(busy), .done(done), .changed(changed), .ovf(ovf),
      .new_centroids(new_centroids));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [K*D*W-1:0] cent;
      logic             chg;
      int               lat;
      time              t0;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned sums[K][D];
   int unsigned cnts[K];
   logic [7:0]  cent_m[K][D];
   bit          ovf_m;
   int          n_chk = 0, n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_chk++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, expv);
   endtask

   task automatic model_clear();
      for (int i = 0; i < K; i++) begin
         cnts[i] = 0;
         for (int j = 0; j < D; j++) sums[i][j] = 0;
      end
      ovf_m = 0;
   endtask

   task automatic model_update(input time t0);
      exp_t e;
      int e0 = 0, enz = 0;
      logic [7:0] q;
      e.chg  = 1'b0;
      e.cent = '0;
      for (int i = 0; i < K; i++)
         for (int j = 0; j < D; j++) begin
            if (cnts[i] == 0) e0++;
            else begin
               enz++;
               q = 8'(sums[i][j] / cnts[i]);
               if (q != cent_m[i][j]) e.chg = 1'b1;
               cent_m[i][j] = q;
            end
         end
      for (int i = 0; i < K; i++)
         for (int j = 0; j < D; j++) e.cent[(i*D+j)*W +: W] = cent_m[i][j];
      e.lat = e0 + enz * 17 + 1;
      e.t0  = t0;
      exp_q.push_back(e);
      model_clear();
   endtask

   task automatic drive(input bit v, input int c, input int x, input int y, input bit u, input bit cl);
      pt_valid   = v;
      pt_class   = 2'(c);
      pt_data    = {8'(y), 8'(x)};
      update_req = u;
      clr        = cl;
      @(posedge clk);
      if (cl) model_clear();
      else begin
         if (v) begin
            if (cnts[c] == 255) ovf_m = 1;
            else begin
               cnts[c]++;
               sums[c][0] += 32'(x);
               sums[c][1] += 32'(y);
            end
         end
         if (u) model_update($time);
      end
      #1;
      pt_valid = 0; update_req = 0; clr = 0;
   endtask

   task automatic wait_done();
      bit seen = 0;
      for (int n = 0; n < 3000 && !seen; n++) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      if (!seen) begin
         n_chk++;
         $display("FAIL done_timeout: got no done expected done within 3000 cycles");
      end
      @(negedge clk);
      chk("ready_after_done", {63'd0, pt_ready}, 64'd1);
   endtask

   always @(negedge clk) begin
      if (!rst && done) begin
         exp_t e;
         if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_done: got done expected none");
         end else begin
            e = exp_q.pop_front();
            chk("centroids", new_centroids, e.cent);
            chk("changed", {63'd0, changed}, {63'd0, e.chg});
            chk("latency", 64'(($time - 5 - e.t0) / 10), 64'(e.lat));
            chk("ovf_at_done", {63'd0, ovf}, 64'd0);
            chk("busy_at_done", {63'd0, busy}, 64'd0);
         end
      end
   end

   task automatic do_update(input bit v, input int c, input int x, input int y);
      drive(v, c, x, y, 1, 0);
      chk("busy_div", {63'd0, busy}, 64'd1);
      chk("ready_div", {63'd0, pt_ready}, 64'd0);
      wait_done();
   endtask

   initial begin
      rst = 1; pt_valid = 0; pt_class = 0; pt_data = 0; clr = 0; update_req = 0;
      model_clear();
      for (int i = 0; i < K; i++) for (int j = 0; j < D; j++) cent_m[i][j] = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", {63'd0, pt_ready}, 64'd1);
      chk("rst_flags", {60'd0, busy, done, changed, ovf}, 64'd0);
      chk("rst_cent", new_centroids, 64'd0);
      rst = 0;

      // basic mean
      drive(1, 1, 10, 20, 0, 0);
      drive(1, 1, 30, 40, 0, 0);
      do_update(0, 0, 0, 0);

      // truncation, then empty update retains everything
      drive(1, 0, 5, 7, 0, 0);
      drive(1, 0, 6, 8, 0, 0);
      do_update(0, 0, 0, 0);
      do_update(0, 0, 0, 0);

      // point accepted in the same cycle as update_req
      do_update(1, 3, 100, 200);

      // clr beats a simultaneous point and update_req
      for (int n = 0; n < 3; n++) drive(1, 2, $urandom_range(0, 255), $urandom_range(0, 255), 0, 0);
      drive(1, 2, 77, 88, 1, 1);
      chk("clr_no_divide", {63'd0, busy}, 64'd0);
      do_update(0, 0, 0, 0);

      // randomized rounds
      for (int r = 0; r < 6; r++) begin
         int n = $urandom_range(0, 12);
         for (int p = 0; p < n; p++)
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3),
                  $urandom_range(0, 255), $urandom_range(0, 255), 0, 0);
         do_update($urandom_range(0, 1), $urandom_range(0, 3),
                   $urandom_range(0, 255), $urandom_range(0, 255));
      end

      // count saturation
      for (int p = 0; p < 256; p++) drive(1, 0, 255, 255, 0, 0);
      chk("ovf_sticky", {63'd0, ovf}, {63'd0, ovf_m});
      do_update(0, 0, 0, 0);

      // async reset in the middle of DIVIDE
      drive(1, 1, 50, 60, 0, 0);
      drive(1, 1, 52, 62, 1, 0);
      repeat (5) @(posedge clk);
      #2 rst = 1;
      #1;
      chk("rst_mid_busy", {63'd0, busy}, 64'd0);
      chk("rst_mid_cent", new_centroids, 64'd0);
      exp_q.delete();
      model_clear();
      for (int i = 0; i < K; i++) for (int j = 0; j < D; j++) cent_m[i][j] = 0;
      @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("rst_mid_ready", {63'd0, pt_ready}, 64'd1);
      drive(1, 2, 9, 4, 0, 0);
      do_update(1, 2, 20, 11);

      repeat (3) @(negedge clk);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
